// File: rtl/spi_mem_responder_if.sv
// SPI target bus bundle for spi_mem_responder.
// Carries the SPI pins (cs_n, sclk, mosi, miso, miso_oe), the busy flag and
// the backdoor preload/inspect port (bd_addr, bd_we, bd_wdata, bd_rdata).
// master: the SPI controller / bench side; slave: the memory responder.
interface spi_mem_responder_if #(
  parameter int AW = 8
);
  logic          cs_n;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic          busy;
  logic [AW-1:0] bd_addr;
  logic          bd_we;
  logic [7:0]    bd_wdata;
  logic [7:0]    bd_rdata;

  modport master (
    output cs_n, sclk, mosi, bd_addr, bd_we, bd_wdata,
    input  miso, miso_oe, busy, bd_rdata
  );

  modport slave (
    input  cs_n, sclk, mosi, bd_addr, bd_we, bd_wdata,
    output miso, miso_oe, busy, bd_rdata
  );
endinterface

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target answering READ (0x03) and WRITE (0x02): 8-bit command,
// 24-bit address (low AW bits kept), then MSB-first data bytes with an
// auto-incrementing, wrapping address into an internal byte array.
// All SPI pins are oversampled in the clk domain (2-flop sync + sclk edge
// detect), so SPI events are acted on 3 clk after they hit the pins.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   bus        : spi_mem_responder_if.slave (SPI pins, busy, backdoor port)
module spi_mem_responder #(
  parameter int MEM_BYTES = 256,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic clk,
  input  logic rst_n,
  spi_mem_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t        state;
  logic [1:0]    cs_sy;
  logic [1:0]    mosi_sy;
  logic [2:0]    sclk_sy;     // [2] is the edge-detect history flop
  logic [2:0]    bit_cnt;
  logic [4:0]    addr_cnt;
  logic [7:0]    shift;
  logic [7:0]    tx_shift;
  logic [AW-1:0] addr;
  logic          is_rd;
  logic          miso_q;
  logic          oe_q;

  logic [7:0]    mem [MEM_BYTES];

  logic cs_s, mosi_s, rise, fall, spi_we;
  logic [7:0] shift_nx;

  // Synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sy   <= 2'b11;
      sclk_sy <= 3'b000;
      mosi_sy <= 2'b00;
    end else begin
      cs_sy   <= {cs_sy[0], bus.cs_n};
      sclk_sy <= {sclk_sy[1:0], bus.sclk};
      mosi_sy <= {mosi_sy[0], bus.mosi};
    end
  end

  assign cs_s     = cs_sy[1];
  assign mosi_s   = mosi_sy[1];
  assign rise     = sclk_sy[1] & ~sclk_sy[2];
  assign fall     = ~sclk_sy[1] & sclk_sy[2];
  assign shift_nx = {shift[6:0], mosi_s};

  // Byte completes on the 8th rise of a WRITE byte; only then is mem touched,
  // so a byte cut short by cs_n is simply dropped.
  assign spi_we = (state == WRITE) && !cs_s && rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      addr_cnt <= 5'd0;
      shift    <= 8'h00;
      tx_shift <= 8'h00;
      addr     <= '0;
      is_rd    <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else if (cs_s) begin
      state   <= IDLE;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      bit_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state   <= CMD;
          bit_cnt <= 3'd0;
          shift   <= 8'h00;
          addr    <= '0;
        end
        CMD: if (rise) begin
          shift   <= shift_nx;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            addr_cnt <= 5'd0;
            if (shift_nx == 8'h03) begin
              is_rd <= 1'b1;
              state <= ADDR;
            end else if (shift_nx == 8'h02) begin
              is_rd <= 1'b0;
              state <= ADDR;
            end else begin
              state <= IGNORE;
            end
          end
        end
        ADDR: if (rise) begin
          // shifting through an AW-bit register drops the upper address bits
          addr     <= {addr[AW-2:0], mosi_s};
          addr_cnt <= addr_cnt + 5'd1;
          if (addr_cnt == 5'd23) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            if (is_rd) begin
              state <= READ;
              oe_q  <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        READ: begin
          if (fall) begin
            if (bit_cnt == 3'd0) begin
              miso_q   <= mem[addr][7];
              tx_shift <= {mem[addr][6:0], 1'b0};
              addr     <= addr + AW'(1);
            end else begin
              miso_q   <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          if (rise) bit_cnt <= bit_cnt + 3'd1;
        end
        WRITE: if (rise) begin
          shift   <= shift_nx;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) addr <= addr + AW'(1);
        end
        IGNORE: miso_q <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is not reset. SPI write is ordered last so it wins a same-address
  // collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bus.bd_we) mem[bus.bd_addr] <= bus.bd_wdata;
    if (spi_we)    mem[addr]        <= shift_nx;
  end

  assign bus.bd_rdata = mem[bus.bd_addr];
  assign bus.miso     = miso_q;
  assign bus.miso_oe  = oe_q;
  assign bus.busy     = ~cs_s;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: directed scenarios plus random
// read/write bursts checked against a plain byte-array memory model.
module tb_spi_mem_responder;
  localparam int MB = 256;
  localparam int AW = 8;
  localparam int H  = 5;   // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_responder_if #(.AW(AW)) bus();

  spi_mem_responder #(.MEM_BYTES(MB), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [7:0]    ref_mem [MB];
  logic [7:0]    txd [8];
  logic [7:0]    rxd [8];
  int            n_chk = 0;
  int            n_fail = 0;
  logic          seen_miso, seen_oe, and_oe, busy_mid;
  logic [AW-1:0] coll_addr;
  logic [7:0]    coll_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bd_addr = a; bus.bd_wdata = d; bus.bd_we = 1'b1;
    @(negedge clk);
    bus.bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.bd_addr = a;
    #1 d = bus.bd_rdata;
  endtask

  // One mode-0 bit: drive mosi in the low phase, sample miso just before the
  // rise. Optional backdoor pulse lands on the clk edge that acts on the rise.
  task automatic spi_bit(input logic b, input logic pulse, output logic r);
    bus.mosi = b;
    clks(H);
    r = bus.miso;
    seen_miso |= bus.miso;
    seen_oe   |= bus.miso_oe;
    and_oe    &= bus.miso_oe;
    bus.sclk = 1'b1;
    clks(2);
    if (pulse) begin
      bus.bd_addr = coll_addr; bus.bd_wdata = coll_data; bus.bd_we = 1'b1;
    end
    clks(1);
    bus.bd_we = 1'b0;
    clks(H - 3);
    bus.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic pulse, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], pulse && (i == 0), b);
      rx[i] = b;
    end
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] a, input int n,
                         input int tail, input int pulse_byte, output logic hdr_oe);
    logic [7:0] d;
    logic b;
    @(negedge clk);
    bus.cs_n = 1'b0; bus.sclk = 1'b0;
    seen_miso = 1'b0; seen_oe = 1'b0; and_oe = 1'b1;
    spi_byte(cmd, 1'b0, d);
    busy_mid = bus.busy;
    spi_byte(a[23:16], 1'b0, d);
    spi_byte(a[15:8], 1'b0, d);
    spi_byte(a[7:0], 1'b0, d);
    hdr_oe = seen_oe;
    and_oe = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_byte(txd[i], i == pulse_byte, d);
      rxd[i] = d;
    end
    for (int i = 0; i < tail; i++) spi_bit(1'b1, 1'b0, b);
    clks(H);
    bus.cs_n = 1'b1;
    clks(6);
  endtask

  task automatic mem_cmp(input string tag);
    logic [7:0] d;
    int bad = 0;
    for (int i = 0; i < MB; i++) begin
      bd_read(AW'(i), d);
      if (d !== ref_mem[i]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, old12, old41;
    logic hdr_oe, b;
    logic [23:0] a;
    int n, tail;

    bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.bd_we = 1'b0; bus.bd_addr = '0; bus.bd_wdata = 8'h00;
    clks(3);
    chk("rst_out", {bus.miso, bus.miso_oe, bus.busy}, 3'b000);
    rst_n = 1'b1;
    clks(2);

    for (int i = 0; i < MB; i++) bd_write(AW'(i), 8'($urandom));
    bd_write(8'h33, 8'hC6);
    chk("bd_next_cycle", bus.bd_rdata, 8'hC6);

    // write burst
    old12 = ref_mem[8'h12];
    txd[0] = 8'hA5; txd[1] = 8'h3C;
    spi_txn(8'h02, 24'h000010, 2, 0, -1, hdr_oe);
    chk("wr_busy", busy_mid, 1'b1);
    chk("wr_busy_after", bus.busy, 1'b0);
    ref_mem[8'h10] = 8'hA5; ref_mem[8'h11] = 8'h3C;
    bd_read(8'h10, d); chk("wr_10", d, 8'hA5);
    bd_read(8'h11, d); chk("wr_11", d, 8'h3C);
    bd_read(8'h12, d); chk("wr_12", d, old12);

    // read burst
    bd_write(8'h20, 8'h11); bd_write(8'h21, 8'h22);
    bd_write(8'h22, 8'h33); bd_write(8'h23, 8'h44);
    for (int i = 0; i < 4; i++) txd[i] = 8'h00;
    spi_txn(8'h03, 24'h000020, 4, 0, -1, hdr_oe);
    chk("rd_data", {rxd[0], rxd[1], rxd[2], rxd[3]}, 32'h11223344);
    chk("rd_hdr_oe", hdr_oe, 1'b0);
    chk("rd_data_oe", and_oe, 1'b1);
    chk("rd_oe_after", bus.miso_oe, 1'b0);

    // wrap + truncation
    bd_write(8'hFF, 8'hEE); bd_write(8'h00, 8'h77);
    spi_txn(8'h03, 24'hFF00FF, 2, 0, -1, hdr_oe);
    chk("wrap", {rxd[0], rxd[1]}, 16'hEE77);

    // unsupported command
    txd[0] = 8'hFF; txd[1] = 8'hFF;
    spi_txn(8'h9F, 24'hFFFFFF, 2, 0, -1, hdr_oe);
    chk("ign_miso", seen_miso, 1'b0);
    chk("ign_oe", seen_oe, 1'b0);
    mem_cmp("ign_mem");

    // abort mid-byte
    old41 = ref_mem[8'h41];
    txd[0] = 8'h5A;
    spi_txn(8'h02, 24'h000040, 1, 4, -1, hdr_oe);
    ref_mem[8'h40] = 8'h5A;
    bd_read(8'h40, d); chk("abort_40", d, 8'h5A);
    bd_read(8'h41, d); chk("abort_41", d, old41);
    spi_txn(8'h03, 24'h000040, 2, 0, -1, hdr_oe);
    chk("abort_next", {rxd[0], rxd[1]}, {8'h5A, old41});

    // collisions: same address -> SPI wins; different -> both land
    txd[0] = 8'h96; coll_addr = 8'h50; coll_data = 8'h69;
    spi_txn(8'h02, 24'h000050, 1, 0, 0, hdr_oe);
    ref_mem[8'h50] = 8'h96;
    bd_read(8'h50, d); chk("coll_same", d, 8'h96);
    txd[0] = 8'hC3; coll_addr = 8'h61; coll_data = 8'h3C;
    spi_txn(8'h02, 24'h000060, 1, 0, 0, hdr_oe);
    ref_mem[8'h60] = 8'hC3; ref_mem[8'h61] = 8'h3C;
    bd_read(8'h60, d); chk("coll_diff_spi", d, 8'hC3);
    bd_read(8'h61, d); chk("coll_diff_bd", d, 8'h3C);

    // reset in the middle of a read data phase
    @(negedge clk);
    bus.cs_n = 1'b0;
    spi_byte(8'h03, 1'b0, d);
    spi_byte(8'h00, 1'b0, d);
    spi_byte(8'h00, 1'b0, d);
    spi_byte(8'h20, 1'b0, d);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, b);
    clks(H);
    chk("pre_rst_oe", bus.miso_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {bus.miso, bus.miso_oe, bus.busy}, 3'b000);
    bus.cs_n = 1'b1; bus.sclk = 1'b0;
    clks(3);
    chk("midrst_hold", {bus.miso, bus.miso_oe, bus.busy}, 3'b000);
    rst_n = 1'b1;
    clks(4);
    spi_txn(8'h03, 24'h000020, 4, 0, -1, hdr_oe);
    chk("post_rst_rd", {rxd[0], rxd[1], rxd[2], rxd[3]}, 32'h11223344);

    // random bursts vs model
    for (int t = 0; t < 30; t++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
        tail = $urandom_range(0, 7);
        spi_txn(8'h02, a, n, tail, -1, hdr_oe);
        for (int i = 0; i < n; i++) ref_mem[8'(a[7:0] + 8'(i))] = txd[i];
      end else begin
        for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
        spi_txn(8'h03, a, n, 0, -1, hdr_oe);
        for (int i = 0; i < n; i++)
          chk($sformatf("rnd_rd t%0d b%0d", t, i), rxd[i], ref_mem[8'(a[7:0] + 8'(i))]);
        chk($sformatf("rnd_oe t%0d", t), and_oe, 1'b1);
      end
    end
    mem_cmp("final_mem");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

Synthesizable SPI target that answers the read (0x03) and write (0x02) command set issued by our SPI controller: 8-bit command, 24-bit address, then data bytes MSB-first with an auto-incrementing address. It is backed by a small internal byte array. It sits on the far side of the MCU's SPI bus as an on-chip scratch memory, or in the top-level bench as a cycle-faithful flash/RAM stand-in. All SPI inputs are oversampled in the system clock domain. A backdoor port preloads and inspects memory.

## Interface
Parameters:
- MEM_BYTES, 256: memory depth in bytes; power of two, 16..4096.
- AW, $clog2(MEM_BYTES): internal address width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cs_n  input  1  SPI chip select, active low.
- sclk  input  1  SPI clock; mode 0 (idle low, sample on rise, shift on fall).
- mosi  input  1  controller-to-target data.
- miso  output  1  target-to-controller data; 0 whenever miso_oe=0.
- miso_oe  output  1  high while in the READ data phase.
- busy  output  1  high whenever the synchronized cs_n is low.
- bd_addr  input  AW  backdoor address.
- bd_we  input  1  backdoor write strobe; writes bd_wdata at posedge clk.
- bd_wdata  input  8  backdoor write data.
- bd_rdata  output  8  combinational mem[bd_addr].

## Operation
- Sync: cs_n, sclk and mosi each pass through 2-flop synchronizers. Reset values are cs_n=1, sclk=0, mosi=0. A third sclk flop provides edge detection: rise = s & ~prev, fall = ~s & prev.
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE. Within CMD/ADDR/READ/WRITE, a 3-bit bit_cnt counts bits per byte.
- IDLE: synchronized cs_n low -> CMD, with bit_cnt=0, shift=0 and addr=0.
- CMD: each rise shifts mosi into the 8-bit shift register. On the 8th rise:
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (write).
  - Any other value -> IGNORE.
- ADDR: 24 rises shift the address in. Only the low AW bits are kept; upper bits are discarded. On the 24th rise -> READ or WRITE.
- READ:
  - On each fall with bit_cnt==0: miso <= mem[addr][7], tx_shift <= mem[addr]<<1, addr <= addr+1.
  - On every other fall: miso <= tx_shift[7], and tx_shift shifts left.
  - bit_cnt increments on each rise.
  - miso_oe=1 throughout READ.
- WRITE:
  - Each rise shifts mosi in.
  - On the 8th rise of a byte: mem[addr] <= {shift[6:0], mosi_sync}, addr <= addr+1, bit_cnt wraps to 0.
- addr is AW bits wide and wraps from MEM_BYTES-1 to 0.
- IGNORE: miso=0 and no memory writes until cs_n deasserts.
- cs_n high (synchronized) in any state:
  - Go to IDLE the same cycle.
  - Clear miso, miso_oe and bit_cnt.
  - A partially received write byte is discarded.
- Collision: a backdoor write and an SPI write to the same address in the same cycle -> the SPI write wins. At different addresses, both writes take effect.
- Memory contents are not reset; the bench preloads them via the backdoor.

## Timing
- Reset (rst_n low, async) forces:
  - state=IDLE, miso=0, miso_oe=0, busy=0.
  - addr=0, bit_cnt=0.
  - All synchronizer flops to their reset values.
- Input-to-action latency is 3 clk: edges are acted on 3 clk after they appear on the pins.
- sclk constraints:
  - High and low phases each >= 4 clk periods.
  - cs_n setup to the first rise >= 4 clk.
  - mosi stable >= 3 clk around each rise.
- miso timing:
  - miso updates 3 clk after an sclk fall.
  - The first data bit is driven after the fall that follows address bit 24.
  - miso is valid >= 1 clk before the next rise when the half period is >= 4 clk.
- A backdoor write is visible on bd_rdata the cycle after bd_we.
- An SPI write is visible on bd_rdata 1 clk after the 8th data rise is detected.
- busy follows synchronized cs_n with 2 clk latency.

## Test plan
- Reset: hold rst_n low mid-stream -> miso=0, miso_oe=0, busy=0. After release, a new 0x03 transaction reads correctly.
- Write burst: cs_n low, send 0x02, 0x000010, then 0xA5, 0x3C; cs_n high -> bd_rdata at 0x10=0xA5 and at 0x11=0x3C; 0x12 unchanged.
- Read burst: preload 0x20..0x23 = 11 22 33 44; send 0x03, 0x000020 and clock 32 more bits -> MISO returns 0x11223344; miso_oe high only during the data phase.
- Wrap and address truncation: preload mem[255]=0xEE and mem[0]=0x77; read from 0xFF00FF with MEM_BYTES=256 -> returns 0xEE then 0x77.
- Unsupported command: send 0x9F followed by 40 bits of 0xFF -> miso stays 0, miso_oe stays 0, and no memory byte changes.
- Abort: write 0x02, 0x000040, 0x5A, then 4 bits of 0xFF, then cs_n high -> mem[0x40]=0x5A and mem[0x41] unchanged. The next transaction starts cleanly in CMD.
